// File: rtl/hc_pkg.sv
// Shared definitions for the hysteresis scan controller: FSM encoding,
// default threshold and channel-index width helper.
package hc_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_EVAL   = 2'd2,
      S_DECIDE = 2'd3
   } state_t;

   localparam int DEF_TH = 10;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hyst_gt.sv
// Hysteresis compare: gt = a > b + TH, evaluated one bit wider than the
// operands so that b + TH never wraps.
module hyst_gt
   import hc_pkg::*;
#(
   parameter int W  = 8,
   parameter int TH = DEF_TH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt
);

   localparam logic [W:0] TH_X = (W+1)'(TH);

   assign gt = {1'b0, a} > ({1'b0, b} + TH_X);

endmodule

// File: rtl/hyst_scan_ctrl.sv
// Scans N_CH channels through a shared sampler and tracks the dominant
// channel, switching only after a challenger wins HOLD consecutive scans.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for en
// S_REQ    | requesting samples, one handshake per channel
// S_EVAL   | one channel per cycle against leader sel
// S_DECIDE | apply hold-off, update sel, pulse scan_done/switch
module hyst_scan_ctrl
   import hc_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 8,
   parameter int TH   = DEF_TH,
   parameter int HOLD = 2,
   localparam int CW  = idx_w(N_CH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          samp_req,
   output logic [CW-1:0] samp_ch,
   input  logic          samp_valid,
   input  logic [W-1:0]  samp_data,
   output logic [CW-1:0] sel,
   output logic          sel_vld,
   output logic          scan_done,
   output logic          switch
);

   localparam int            HW     = $clog2(HOLD + 1);
   localparam logic [CW-1:0] LAST   = CW'(N_CH - 1);
   localparam logic [HW-1:0] HOLD_C = HW'(HOLD);

   state_t        state, state_nx;
   logic [W-1:0]  val [N_CH];
   logic [CW-1:0] ch;
   logic [CW-1:0] best_idx;
   logic [CW-1:0] prev;
   logic [W-1:0]  best_val;
   logic          best_vld;
   logic [HW-1:0] cnt;
   logic [HW-1:0] cnt_inc;
   logic          hs;
   logic          last;
   logic          gt;
   logic          cand;
   logic          take;
   logic          hit;

   assign samp_req = (state == S_REQ);
   assign samp_ch  = ch;
   assign hs       = samp_req && samp_valid;
   assign last     = (ch == LAST);

   hyst_gt #(.W(W), .TH(TH)) u_gt (
      .a  (val[ch]),
      .b  (val[sel]),
      .gt (gt)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      // before the first decision every channel competes, giving plain argmax
      cand     = sel_vld ? gt : 1'b1;
      take     = (state == S_EVAL) && cand && (!best_vld || (val[ch] > best_val));
      cnt_inc  = (best_idx == prev) ? cnt + HW'(1) : HW'(1);
      hit      = sel_vld && best_vld && (cnt_inc == HOLD_C);
      case (state)
         S_IDLE:   if (en) state_nx = S_REQ;
         S_REQ:    if (hs && last) state_nx = S_EVAL;
         S_EVAL:   if (last) state_nx = S_DECIDE;
         S_DECIDE: state_nx = en ? S_REQ : S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // sample store is deliberately unreset; a reset in the same cycle drops the data
   always_ff @(posedge clk) begin
      if (!rst && hs) val[ch] <= samp_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch        <= '0;
         sel       <= '0;
         sel_vld   <= 1'b0;
         scan_done <= 1'b0;
         switch    <= 1'b0;
         cnt       <= '0;
         prev      <= '0;
         best_vld  <= 1'b0;
         best_idx  <= '0;
         best_val  <= '0;
      end else begin
         scan_done <= (state == S_DECIDE);
         switch    <= (state == S_DECIDE) && hit;
         case (state)
            S_IDLE: ch <= '0;
            S_REQ: begin
               if (hs) begin
                  ch <= last ? '0 : ch + CW'(1);
                  if (last) best_vld <= 1'b0;
               end
            end
            S_EVAL: begin
               ch <= last ? '0 : ch + CW'(1);
               if (take) begin
                  best_vld <= 1'b1;
                  best_idx <= ch;
                  best_val <= val[ch];
               end
            end
            S_DECIDE: begin
               ch <= '0;
               if (!sel_vld) begin
                  sel     <= best_idx;
                  sel_vld <= 1'b1;
                  cnt     <= '0;
               end else if (!best_vld) begin
                  cnt <= '0;
               end else begin
                  prev <= best_idx;
                  if (hit) begin
                     sel <= best_idx;
                     cnt <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            default: ch <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_hyst_scan_ctrl.sv
// Directed bench for hyst_scan_ctrl (N_CH=4, W=8, TH=10, HOLD=2) with
// hand-computed expectations checked by immediate assertions.
module tb_hyst_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       samp_req;
   logic [1:0] samp_ch;
   logic       samp_valid;
   logic [7:0] samp_data;
   logic [1:0] sel;
   logic       sel_vld;
   logic       scan_done;
   logic       switch;

   int         total = 0;
   int         bad   = 0;
   int         cyc;
   logic [7:0] vec [4];

   always #5 clk = ~clk;

   hyst_scan_ctrl #(.N_CH(4), .W(8), .TH(10), .HOLD(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .samp_req   (samp_req),
      .samp_ch    (samp_ch),
      .samp_valid (samp_valid),
      .samp_data  (samp_data),
      .sel        (sel),
      .sel_vld    (sel_vld),
      .scan_done  (scan_done),
      .switch     (switch)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_req"},  32'(samp_req),  0);
      check({tag, "_ch"},   32'(samp_ch),   0);
      check({tag, "_sel"},  32'(sel),       0);
      check({tag, "_vld"},  32'(sel_vld),   0);
      check({tag, "_done"}, 32'(scan_done), 0);
      check({tag, "_sw"},   32'(switch),    0);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      en         = 1'b0;
      samp_valid = 1'b0;
      samp_data  = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start(input string tag);
      en = 1'b1;
      @(negedge clk);
      check({tag, "_req_after_en"}, 32'(samp_req), 1);
   endtask

   // Runs from a negedge in REQ cycle 0 until scan_done is seen; one sample
   // accepted every 'per' REQ cycles; en dropped at cycle drop_at if >= 0.
   task automatic scan(input int a, input int b, input int c, input int d,
                       input int per, input int drop_at, output int n);
      int         s;
      logic       ok;
      logic [1:0] pch;
      logic       preq;
      logic       pvld;
      vec[0] = 8'(a);
      vec[1] = 8'(b);
      vec[2] = 8'(c);
      vec[3] = 8'(d);
      s  = 0;
      ok = 1'b1;
      n  = 0;
      while (n < 200) begin
         if (n == drop_at) en = 1'b0;
         samp_valid = (s == per - 1);
         samp_data  = vec[samp_ch];
         pch  = samp_ch;
         preq = samp_req;
         pvld = samp_valid;
         @(negedge clk);
         n++;
         if (preq) begin
            if (pvld) s = 0;
            else begin
               s++;
               if (samp_ch !== pch || samp_req !== 1'b1) ok = 1'b0;
            end
         end
         if (scan_done === 1'b1) break;
      end
      check("stall_stable", 32'(ok), 1);
   endtask

   task automatic post(input string tag, input int n, input int exp_n,
                       input int exp_sel, input int exp_sw);
      check({tag, "_cycles"}, 32'(n),         32'(exp_n));
      check({tag, "_sel"},    32'(sel),       32'(exp_sel));
      check({tag, "_sw"},     32'(switch),    32'(exp_sw));
      check({tag, "_vld"},    32'(sel_vld),   1);
      check({tag, "_done"},   32'(scan_done), 1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; samp_valid = 1'b0; samp_data = 8'd0;

      // reset state, idle with en low
      do_reset();
      check_reset_outs("rst");
      @(negedge clk);
      check("idle_no_req", 32'(samp_req), 0);

      // first scan: argmax
      start("t1");
      scan(20, 50, 30, 40, 1, -1, cyc);  post("t1", cyc, 9, 1, 0);

      // hysteresis boundary and hold-off
      scan(20, 50, 30, 60, 1, -1, cyc);  post("t2a", cyc, 9, 1, 0);
      scan(20, 50, 30, 61, 1, -1, cyc);  post("t2b", cyc, 9, 1, 0);
      scan(20, 50, 30, 61, 1, -1, cyc);  post("t2c", cyc, 9, 3, 1);

      // challenger change restarts the hold count
      do_reset();
      start("t3");
      scan(20, 50, 30, 40, 1, -1, cyc);  post("t3a", cyc, 9, 1, 0);
      scan(20, 50, 30, 61, 1, -1, cyc);  post("t3b", cyc, 9, 1, 0);
      scan(20, 50, 61, 30, 1, -1, cyc);  post("t3c", cyc, 9, 1, 0);
      scan(20, 50, 61, 30, 1, -1, cyc);  post("t3d", cyc, 9, 2, 1);

      // no wrap on leader + TH near full scale
      scan(0, 0, 250, 255, 1, -1, cyc);  post("t4a", cyc, 9, 2, 0);
      scan(0, 0, 250, 255, 1, -1, cyc);  post("t4b", cyc, 9, 2, 0);
      scan(0, 0, 250, 255, 1, -1, cyc);  post("t4c", cyc, 9, 2, 0);
      // leader at zero, challenger one above threshold
      scan(0, 0, 0, 11, 1, -1, cyc);     post("t4d", cyc, 9, 2, 0);
      scan(0, 0, 0, 11, 1, -1, cyc);     post("t4e", cyc, 9, 3, 1);

      // tie between challengers: lowest index wins
      do_reset();
      start("t4t");
      scan(20, 50, 30, 40, 1, -1, cyc);  post("t4f", cyc, 9, 1, 0);
      scan(61, 50, 61, 20, 1, -1, cyc);  post("t4g", cyc, 9, 1, 0);
      scan(61, 50, 61, 20, 1, -1, cyc);  post("t4h", cyc, 9, 0, 1);

      // back-pressure: one accept per four cycles
      scan(61, 50, 61, 20, 4, -1, cyc);  post("t5", cyc, 21, 0, 0);

      // reset in the middle of REQ, with valid data in the same cycle
      samp_valid = 1'b1;
      samp_data  = vec[samp_ch];
      @(negedge clk);
      check("t6_mid_req", 32'(samp_req), 1);
      check("t6_mid_ch",  32'(samp_ch),  1);
      samp_data = vec[samp_ch];
      rst = 1'b1;
      @(negedge clk);
      check_reset_outs("t6_rst");
      rst = 1'b0;
      @(negedge clk);
      check("t6_restart_req", 32'(samp_req), 1);

      // en dropped mid-scan: scan completes, then idle
      scan(20, 50, 30, 40, 1, 2, cyc);   post("t6b", cyc, 9, 1, 0);
      check("t6_idle_req", 32'(samp_req), 0);
      @(negedge clk);
      check("t6_idle_req2",  32'(samp_req),  0);
      check("t6_idle_done",  32'(scan_done), 0);
      check("t6_idle_sel",   32'(sel),       1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
